// File: rtl/execute_rep_sequencer.sv
// execute_rep_sequencer
// Purpose     : execute-stage sequencer in front of WB. Single-shot ALU ops pass straight
//               through; REP/REPNE string ops iterate internally, one WB entry per iteration.
// Latency     : a pushed entry is visible on o_wb_v the next cycle; a REP op starts
//               iterating the cycle after it is accepted. Throughput is 1 entry/cycle.
// Backpressure: i_wb_stall holds the FIFO head. When the FIFO is full and not popping,
//               o_ex_ready drops (IDLE) or the iteration state holds (ITER).
// Optional    : define EX_PERF_CNT_EN to add o_perf_iter_cnt (non-NOP push counter).
// Ports:
//   i_clk, i_clr (sync active-high reset), i_flush (sync pipeline flush)
//   EX side : i_ex_v / o_ex_ready handshake, i_ex_rep, i_ex_repne, i_ex_aluk, i_ex_a,
//             i_ex_b, i_ex_stride, i_ex_count, i_ex_flags_in
//   WB side : o_wb_v / i_wb_stall handshake, o_wb_result, o_wb_a_next, o_wb_count,
//             o_wb_flags, o_wb_last, o_wb_nop
//   o_busy  : FSM not IDLE or FIFO non-empty
module execute_rep_sequencer #(
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_flush,
  input  logic              i_ex_v,
  output logic              o_ex_ready,
  input  logic              i_ex_rep,
  input  logic              i_ex_repne,
  input  logic [2:0]        i_ex_aluk,
  input  logic [DATA_W-1:0] i_ex_a,
  input  logic [DATA_W-1:0] i_ex_b,
  input  logic [DATA_W-1:0] i_ex_stride,
  input  logic [CNT_W-1:0]  i_ex_count,
  input  logic [31:0]       i_ex_flags_in,
  output logic              o_wb_v,
  input  logic              i_wb_stall,
  output logic [DATA_W-1:0] o_wb_result,
  output logic [DATA_W-1:0] o_wb_a_next,
  output logic [CNT_W-1:0]  o_wb_count,
  output logic [31:0]       o_wb_flags,
  output logic              o_wb_last,
  output logic              o_wb_nop,
  output logic              o_busy
`ifdef EX_PERF_CNT_EN
  ,
  output logic [31:0]       o_perf_iter_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_OR   = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_XOR  = 3'd3;
  localparam logic [2:0] ALU_SUB  = 3'd4;
  localparam logic [2:0] ALU_PASA = 3'd5;
  localparam logic [2:0] ALU_PASB = 3'd6;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] a_next;
    logic [CNT_W-1:0]  count;
    logic [31:0]       flags;
    logic              last;
    logic              nop;
  } entry_t;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic [31:0]       flg;
  } alu_t;

  typedef enum logic {S_IDLE = 1'b0, S_ITER = 1'b1} state_t;

  // ALU plus flag update: CF[0], ZF[6], SF[7], OF[11]; all other bits pass through.
  function automatic alu_t alu_f(input logic [2:0] k, input logic [DATA_W-1:0] a,
                                 input logic [DATA_W-1:0] b, input logic [31:0] fin);
    alu_t        o;
    logic [DATA_W:0] wide;
    logic        cf;
    logic        of;
    wide = '0;
    cf   = 1'b0;
    of   = 1'b0;
    case (k)
      ALU_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        cf   = wide[DATA_W];
        of   = (a[DATA_W-1] == b[DATA_W-1]) && (wide[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        // Extra top bit of the widened difference is the borrow.
        wide = {1'b0, a} - {1'b0, b};
        cf   = wide[DATA_W];
        of   = (a[DATA_W-1] != b[DATA_W-1]) && (wide[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_OR:   wide = {1'b0, a | b};
      ALU_AND:  wide = {1'b0, a & b};
      ALU_XOR:  wide = {1'b0, a ^ b};
      ALU_PASA: wide = {1'b0, a};
      ALU_PASB: wide = {1'b0, b};
      default:  wide = {1'b0, ~a};
    endcase
    o.res     = wide[DATA_W-1:0];
    o.flg     = fin;
    o.flg[0]  = cf;
    o.flg[6]  = (o.res == '0);
    o.flg[7]  = o.res[DATA_W-1];
    o.flg[11] = of;
    return o;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_stride;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_aluk;
  logic              r_repne;
  logic [31:0]       r_flags;

  entry_t            r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr;
  logic [PTR_W-1:0]  r_rd;
  logic [OCC_W-1:0]  r_occ;

  logic              w_wb_v;
  logic              w_pop;
  logic              w_push_ok;
  logic              w_push;
  logic              w_load;
  logic              w_step;
  logic              w_ex_ready;
  logic              w_it_last;
  logic [CNT_W-1:0]  w_it_cnt;
  entry_t            w_push_dat;
  entry_t            w_head;
  alu_t              w_ex_alu;
  alu_t              w_it_alu;

  // FIFO handshake: a full FIFO still accepts a push when the head pops in the same cycle.
  assign w_wb_v    = (r_occ != '0);
  assign w_pop     = w_wb_v & ~i_wb_stall;
  assign w_push_ok = (r_occ < DEPTH_C) | w_pop;

  assign w_ex_alu  = alu_f(i_ex_aluk, i_ex_a, i_ex_b, i_ex_flags_in);
  assign w_it_alu  = alu_f(r_aluk, r_a, r_b, r_flags);
  assign w_it_cnt  = r_cnt - CNT_W'(1);
  assign w_it_last = (w_it_cnt == '0) | (r_repne & w_it_alu.flg[6]);

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_clr | i_flush) r_state <= S_IDLE;
    else                 r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_load)              w_state_nxt = S_ITER;
      S_ITER:  if (w_step && w_it_last) w_state_nxt = S_IDLE;
      default:                          w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs (handshake and push selection). Flush suppresses any accept or push.
  always_comb begin
    w_ex_ready = 1'b0;
    w_push     = 1'b0;
    w_push_dat = '0;
    w_load     = 1'b0;
    w_step     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ex_ready = w_push_ok;
        if (i_ex_v && w_push_ok && !i_flush) begin
          if (!i_ex_rep) begin
            w_push            = 1'b1;
            w_push_dat.result = w_ex_alu.res;
            w_push_dat.a_next = i_ex_a + i_ex_stride;
            w_push_dat.count  = i_ex_count;
            w_push_dat.flags  = w_ex_alu.flg;
            w_push_dat.last   = 1'b1;
          end else if (i_ex_count == '0) begin
            // Zero-count REP retires as a NOP carrying the incoming flags untouched.
            w_push            = 1'b1;
            w_push_dat.a_next = i_ex_a;
            w_push_dat.flags  = i_ex_flags_in;
            w_push_dat.last   = 1'b1;
            w_push_dat.nop    = 1'b1;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      S_ITER: begin
        if (w_push_ok && !i_flush) begin
          w_push            = 1'b1;
          w_step            = 1'b1;
          w_push_dat.result = w_it_alu.res;
          w_push_dat.a_next = r_a + r_stride;
          w_push_dat.count  = w_it_cnt;
          w_push_dat.flags  = w_it_alu.flg;
          w_push_dat.last   = w_it_last;
        end
      end
      default: ;
    endcase
  end

  // Iteration context
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_a      <= '0;
      r_b      <= '0;
      r_stride <= '0;
      r_cnt    <= '0;
      r_aluk   <= '0;
      r_repne  <= 1'b0;
      r_flags  <= '0;
    end else if (w_load) begin
      r_a      <= i_ex_a;
      r_b      <= i_ex_b;
      r_stride <= i_ex_stride;
      r_cnt    <= i_ex_count;
      r_aluk   <= i_ex_aluk;
      r_repne  <= i_ex_repne;
      r_flags  <= i_ex_flags_in;
    end else if (w_step) begin
      r_a      <= r_a + r_stride;
      r_cnt    <= w_it_cnt;
      r_flags  <= w_it_alu.flg;
    end
  end

  // FIFO pointers/occupancy; pointers wrap naturally since depth is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_clr | i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_occ <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PTR_W'(1);
      if (w_pop)  r_rd <= r_rd + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Storage needs no reset: head data is masked until an entry is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= w_push_dat;
  end

  assign w_head      = w_wb_v ? r_mem[r_rd] : '0;
  assign o_wb_v      = w_wb_v;
  assign o_wb_result = w_head.result;
  assign o_wb_a_next = w_head.a_next;
  assign o_wb_count  = w_head.count;
  assign o_wb_flags  = w_head.flags;
  assign o_wb_last   = w_head.last;
  assign o_wb_nop    = w_head.nop;
  assign o_ex_ready  = w_ex_ready;
  assign o_busy      = (r_state != S_IDLE) | w_wb_v;

`ifdef EX_PERF_CNT_EN
  logic [31:0] r_perf_cnt;
  always_ff @(posedge i_clk) begin
    if (i_clr)                        r_perf_cnt <= '0;
    else if (w_push && !w_push_dat.nop) r_perf_cnt <= r_perf_cnt + 32'd1;
  end
  assign o_perf_iter_cnt = r_perf_cnt;
`endif

endmodule

// File: tb/tb_execute_rep_sequencer.sv
// Bench for execute_rep_sequencer: directed scenarios plus a randomized run checked
// against a queue-based reference model built from the op semantics.
module tb_execute_rep_sequencer;

  logic        clk;
  logic        clr, flush, ex_v, ex_ready, ex_rep, ex_repne;
  logic [2:0]  ex_aluk;
  logic [31:0] ex_a, ex_b, ex_stride, ex_count, ex_flags_in;
  logic        wb_v, wb_stall;
  logic [31:0] wb_result, wb_a_next, wb_count, wb_flags;
  logic        wb_last, wb_nop, busy;
`ifdef EX_PERF_CNT_EN
  logic [31:0] perf_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] a_next;
    logic [31:0] count;
    logic [31:0] flags;
    logic        last;
    logic        nop;
  } ent_t;

  ent_t exp_q[$];

  execute_rep_sequencer #(.DATA_W(32), .CNT_W(32), .FIFO_DEPTH(2)) dut (
    .i_clk(clk), .i_clr(clr), .i_flush(flush), .i_ex_v(ex_v), .o_ex_ready(ex_ready),
    .i_ex_rep(ex_rep), .i_ex_repne(ex_repne), .i_ex_aluk(ex_aluk), .i_ex_a(ex_a),
    .i_ex_b(ex_b), .i_ex_stride(ex_stride), .i_ex_count(ex_count),
    .i_ex_flags_in(ex_flags_in), .o_wb_v(wb_v), .i_wb_stall(wb_stall),
    .o_wb_result(wb_result), .o_wb_a_next(wb_a_next), .o_wb_count(wb_count),
    .o_wb_flags(wb_flags), .o_wb_last(wb_last), .o_wb_nop(wb_nop), .o_busy(busy)
`ifdef EX_PERF_CNT_EN
    , .o_perf_iter_cnt(perf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model_alu(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] k, input logic [31:0] fin,
                                    output logic [31:0] r, output logic [31:0] fo);
    longint          sa, sb, sr;
    longint unsigned ua, ub, ur;
    logic [31:0]     t;
    logic            cf, of;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    cf = 1'b0;
    of = 1'b0;
    case (k)
      3'd0: begin
        ur = ua + ub; r = ur[31:0]; cf = ur[32];
        sr = sa + sb; t = sr[31:0]; of = (sr != longint'($signed(t)));
      end
      3'd4: begin
        r = a - b; cf = (a < b);
        sr = sa - sb; t = sr[31:0]; of = (sr != longint'($signed(t)));
      end
      3'd1: r = a | b;
      3'd2: r = a & b;
      3'd3: r = a ^ b;
      3'd5: r = a;
      3'd6: r = b;
      default: r = ~a;
    endcase
    fo     = fin;
    fo[0]  = cf;
    fo[6]  = (r == 32'd0);
    fo[7]  = r[31];
    fo[11] = of;
  endfunction

  // Expand one accepted op into the full list of WB entries it must produce.
  function automatic void model_op(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] stride, input logic [31:0] cnt,
                                   input logic [2:0] k, input logic rep, input logic repne,
                                   input logic [31:0] fl);
    ent_t        e;
    logic [31:0] ai, f, r, nf;
    if (!rep) begin
      model_alu(a, b, k, fl, r, nf);
      e = '{result: r, a_next: a + stride, count: cnt, flags: nf, last: 1'b1, nop: 1'b0};
      exp_q.push_back(e);
    end else if (cnt == 32'd0) begin
      e = '{result: 32'd0, a_next: a, count: 32'd0, flags: fl, last: 1'b1, nop: 1'b1};
      exp_q.push_back(e);
    end else begin
      ai = a;
      f  = fl;
      for (int i = 1; i <= int'(cnt); i++) begin
        model_alu(ai, b, k, f, r, nf);
        e = '{result: r, a_next: ai + stride, count: cnt - 32'(i), flags: nf,
              last: (i == int'(cnt)) || (repne && nf[6]), nop: 1'b0};
        exp_q.push_back(e);
        ai = ai + stride;
        f  = nf;
        if (e.last) break;
      end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic quiet();
    ex_v = 0; ex_rep = 0; ex_repne = 0; ex_aluk = 0; ex_a = 0; ex_b = 0;
    ex_stride = 0; ex_count = 0; ex_flags_in = 0; flush = 0;
  endtask

  task automatic drive(input logic rep, input logic repne, input logic [2:0] k,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] s,
                       input logic [31:0] c, input logic [31:0] f);
    ex_v = 1; ex_rep = rep; ex_repne = repne; ex_aluk = k; ex_a = a; ex_b = b;
    ex_stride = s; ex_count = c; ex_flags_in = f;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    quiet(); wb_stall = 0; clr = 1;
    @(negedge clk); @(negedge clk); #1;
    vectors++; if (wb_v !== 1'b0)     begin errors++; $display("FAIL reset_wb_v got %b want 0", wb_v); end
    vectors++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ex_ready got %b want 1", ex_ready); end
    vectors++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if ({wb_result, wb_flags, wb_last, wb_nop} !== '0)
      begin errors++; $display("FAIL reset_data got %h/%h/%b/%b want 0", wb_result, wb_flags, wb_last, wb_nop); end
    clr = 0;
  endtask

  task automatic test_add_wrap();
    @(negedge clk); drive(0, 0, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd4, 32'd9, 32'h0000_0202); #1;
    vectors++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL add_ready got %b want 1", ex_ready); end
    @(negedge clk); quiet(); #1;
    vectors++; if (wb_v !== 1'b1) begin errors++; $display("FAIL add_wb_v got %b want 1", wb_v); end
    vectors++; if ({wb_result, wb_flags, wb_last, wb_nop} !== {32'd0, 32'h0000_0243, 1'b1, 1'b0})
      begin errors++; $display("FAIL add_entry got res=%h flg=%h last=%b nop=%b want 0/00000243/1/0", wb_result, wb_flags, wb_last, wb_nop); end
    vectors++; if ({wb_a_next, wb_count} !== {32'd3, 32'd9})
      begin errors++; $display("FAIL add_anext_cnt got %h/%h want 3/9", wb_a_next, wb_count); end
    @(negedge clk); #1;
    vectors++; if (wb_v !== 1'b0) begin errors++; $display("FAIL add_drain got %b want 0", wb_v); end
  endtask

  task automatic test_rep_sub();
    @(negedge clk); drive(1, 0, 3'd4, 32'h100, 32'h0, 32'd4, 32'd3, 32'h0); #1;
    @(negedge clk); quiet(); #1;
    vectors++; if ({wb_v, ex_ready, busy} !== 3'b001)
      begin errors++; $display("FAIL rep_iter_start got v/rdy/busy=%b%b%b want 001", wb_v, ex_ready, busy); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      vectors++;
      if ({wb_v, wb_result, wb_count, wb_last} !== {1'b1, 32'h100 + 32'(4 * i), 32'(2 - i), i == 2})
        begin errors++; $display("FAIL rep_entry%0d got v=%b res=%h cnt=%0d last=%b", i, wb_v, wb_result, wb_count, wb_last); end
    end
    @(negedge clk); #1;
    vectors++; if ({wb_v, busy, ex_ready} !== 3'b001)
      begin errors++; $display("FAIL rep_end got v/busy/rdy=%b%b%b want 001", wb_v, busy, ex_ready); end
  endtask

  task automatic test_repne();
    @(negedge clk); drive(1, 1, 3'd4, 32'h10, 32'h0E, 32'hFFFF_FFFF, 32'd5, 32'h0); #1;
    @(negedge clk); quiet();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      vectors++;
      if ({wb_v, wb_result, wb_count, wb_last, wb_flags[6]} !== {1'b1, 32'(2 - i), 32'(4 - i), i == 2, i == 2})
        begin errors++; $display("FAIL repne_entry%0d got v=%b res=%h cnt=%0d last=%b zf=%b", i, wb_v, wb_result, wb_count, wb_last, wb_flags[6]); end
    end
    @(negedge clk); #1;
    vectors++; if ({wb_v, busy} !== 2'b00) begin errors++; $display("FAIL repne_stop got v/busy=%b%b want 00", wb_v, busy); end
  endtask

  task automatic test_stall_full();
    wb_stall = 1;
    @(negedge clk); drive(1, 0, 3'd0, 32'h0, 32'h10, 32'd1, 32'd4, 32'h0); #1;
    @(negedge clk); quiet();
    @(negedge clk);
    for (int h = 0; h < 2; h++) begin
      @(negedge clk); #1;
      vectors++;
      if ({wb_v, ex_ready, busy, wb_result, wb_count} !== {3'b101, 32'h10, 32'd3})
        begin errors++; $display("FAIL stall_hold%0d got v/rdy/busy=%b%b%b res=%h cnt=%0d want 101/10/3", h, wb_v, ex_ready, busy, wb_result, wb_count); end
    end
    @(negedge clk); wb_stall = 0; #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      vectors++;
      if ({wb_v, wb_result, wb_count, wb_last} !== {1'b1, 32'h10 + 32'(i), 32'(3 - i), i == 3})
        begin errors++; $display("FAIL stall_release%0d got v=%b res=%h cnt=%0d last=%b", i, wb_v, wb_result, wb_count, wb_last); end
    end
    @(negedge clk); #1;
    vectors++; if ({wb_v, busy} !== 2'b00) begin errors++; $display("FAIL stall_dup got v/busy=%b%b want 00", wb_v, busy); end
  endtask

  task automatic test_count0();
    @(negedge clk); drive(1, 0, 3'd0, 32'h55, 32'h1, 32'd1, 32'd0, 32'h1234_5678); #1;
    @(negedge clk); quiet(); #1;
    vectors++;
    if ({wb_v, wb_nop, wb_last, wb_flags, wb_result} !== {3'b111, 32'h1234_5678, 32'd0})
      begin errors++; $display("FAIL count0 got v/nop/last=%b%b%b flg=%h res=%h", wb_v, wb_nop, wb_last, wb_flags, wb_result); end
    @(negedge clk); #1;
    vectors++; if ({wb_v, busy} !== 2'b00) begin errors++; $display("FAIL count0_single got v/busy=%b%b want 00", wb_v, busy); end
  endtask

  task automatic test_flush();
    wb_stall = 1;
    @(negedge clk); drive(1, 0, 3'd0, 32'h0, 32'h1, 32'd1, 32'd5, 32'h0); #1;
    @(negedge clk); quiet();
    @(negedge clk); #1;
    vectors++; if ({wb_v, busy} !== 2'b11) begin errors++; $display("FAIL flush_pre got v/busy=%b%b want 11", wb_v, busy); end
    // Flush wins over a simultaneous single-shot op.
    drive(0, 0, 3'd5, 32'hAA, 32'h0, 32'h0, 32'h0, 32'h0); flush = 1;
    @(negedge clk); quiet(); #1;
    vectors++; if ({wb_v, busy, ex_ready} !== 3'b001)
      begin errors++; $display("FAIL flush_post got v/busy/rdy=%b%b%b want 001", wb_v, busy, ex_ready); end
    @(negedge clk); #1;
    vectors++; if ({wb_v, busy} !== 2'b00) begin errors++; $display("FAIL flush_settle got v/busy=%b%b want 00", wb_v, busy); end
    wb_stall = 0;
  endtask

  task automatic test_random_scoreboard();
    ent_t act, exp;
    logic [31:0] a, s;
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      a = $urandom; s = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 8)) - 32'd4;
      drive($urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom_range(0, 7)), a, $urandom,
            s, 32'($urandom_range(0, 5)), $urandom);
      ex_v = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 1) begin ex_aluk = 3'd4; ex_b = a + s * 32'($urandom_range(0, 3)); end
      wb_stall = ($urandom_range(0, 3) == 0);
      #1;
      if (wb_v && !wb_stall) begin
        act = '{wb_result, wb_a_next, wb_count, wb_flags, wb_last, wb_nop};
        vectors++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rand_extra got %h want none", act); end
        else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin errors++; $display("FAIL rand_entry got %h want %h", act, exp); end
        end
      end
      if (ex_v && ex_ready) model_op(ex_a, ex_b, ex_stride, ex_count, ex_aluk, ex_rep, ex_repne, ex_flags_in);
    end
    @(negedge clk); quiet(); wb_stall = 0;
    for (int c = 0; c < 100 && (busy || exp_q.size() != 0); c++) begin
      #1;
      if (wb_v) begin
        act = '{wb_result, wb_a_next, wb_count, wb_flags, wb_last, wb_nop};
        vectors++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL drain_extra got %h want none", act); end
        else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin errors++; $display("FAIL drain_entry got %h want %h", act, exp); end
        end
      end
      @(negedge clk);
    end
    #1;
    vectors++; if (exp_q.size() != 0 || busy !== 1'b0)
      begin errors++; $display("FAIL drain_done got left=%0d busy=%b want 0/0", exp_q.size(), busy); end
  endtask

  initial begin
    quiet(); wb_stall = 0; clr = 1;
    test_reset();
    test_add_wrap();
    test_rep_sub();
    test_repne();
    test_stall_full();
    test_count0();
    test_flush();
    test_random_scoreboard();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
